// File: rtl/entrada_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | entrada_pkg: shared FSM encoding and default sizes for entrada_chaves      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package entrada_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_VALID    = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_t;

  localparam int c_DATA_W_DEF          = 16;
  localparam int c_DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int c_CNT_W_DEF           = 20;

endpackage
`default_nettype wire

// File: rtl/entrada_chaves_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | entrada_chaves_if: four-phase read handshake between processor and input   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface entrada_chaves_if
  import entrada_pkg::*;
#(
  parameter int DATA_W = c_DATA_W_DEF
) ();

  logic              rd_req;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [7:0]        rd_count;

  modport master (output rd_req, input rd_data, input rd_valid, input rd_count);
  modport slave  (input rd_req, output rd_data, output rd_valid, output rd_count);

endinterface
`default_nettype wire

// File: rtl/entrada_chaves_filtro_tecla.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | filtro_tecla: 2-flop synchronizer plus debouncer for one active-low key.   |
// | Debounce counter built only with ENTRADA_DEBOUNCE_EN. Revision: 1.0        |
// +----------------------------------------------------------------------------+
module filtro_tecla
  import entrada_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = c_CNT_W_DEF
) (
  input  wire  clk,
  input  wire  reset,
  input  wire  i_raw,
  output logic o_db
);

  logic r_meta;
  logic r_sync;
  logic r_db;

  if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES >= (1 << CNT_W))) begin : g_cfg_err
    $error("filtro_tecla: DEBOUNCE_CYCLES does not fit CNT_W");
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
    end
  end

`ifdef ENTRADA_DEBOUNCE_EN
  logic [CNT_W-1:0] r_cnt;

  // Counter measures how long the synchronized key has disagreed with r_db.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_db  <= 1'b1;
    end else if (r_sync == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      r_cnt <= '0;
      r_db  <= r_sync;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db <= 1'b1;
    end else begin
      r_db <= r_sync;
    end
  end
`endif

  assign o_db = r_db;

endmodule
`default_nettype wire

// File: rtl/entrada_chaves.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | entrada_chaves: synchronizes switches/key and hands one switch word per    |
// | key press to the processor. Option macro: ENTRADA_DEBOUNCE_EN. Rev: 1.0    |
// +----------------------------------------------------------------------------+
module entrada_chaves
  import entrada_pkg::*;
#(
  parameter int DATA_W          = c_DATA_W_DEF,
  parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = c_CNT_W_DEF
) (
  input  wire              clk,
  input  wire              reset,
  input  wire [DATA_W-1:0] switch,
  input  wire              ent,
  entrada_chaves_if.slave  bus
);

  logic [DATA_W-1:0] r_sw_meta;
  logic [DATA_W-1:0] r_sw_sync;
  logic              r_req_meta;
  logic              r_req_sync;
  state_t            r_state;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [7:0]        r_count;

  logic              w_key_db;
  state_t            w_state_next;
  logic              w_capture;

  filtro_tecla #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_filtro (
    .clk   (clk),
    .reset (reset),
    .i_raw (ent),
    .o_db  (w_key_db)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
      r_req_meta <= 1'b0;
      r_req_sync <= 1'b0;
    end else begin
      r_sw_meta  <= switch;
      r_sw_sync  <= r_sw_meta;
      r_req_meta <= bus.rd_req;
      r_req_sync <= r_req_meta;
    end
  end

  // A falling request in ARMED wins over a simultaneous press.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_req_sync && w_key_db) w_state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (!r_req_sync) begin
          w_state_next = ST_IDLE;
        end else if (!w_key_db) begin
          w_state_next = ST_VALID;
          w_capture    = 1'b1;
        end
      end
      ST_VALID: begin
        if (!r_req_sync) w_state_next = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (w_key_db) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_count <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_valid <= (w_state_next == ST_VALID);
      if (w_capture) begin
        r_data  <= r_sw_sync;
        r_count <= r_count + 8'd1;
      end
    end
  end

  assign bus.rd_data  = r_data;
  assign bus.rd_valid = r_valid;
  assign bus.rd_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_entrada_chaves.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_entrada_chaves: directed bench with a cycle model for entrada_chaves    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_entrada_chaves;

  localparam int D  = 8;
  localparam int DW = 16;
`ifdef ENTRADA_DEBOUNCE_EN
  localparam int LAT = D + 3;
`else
  localparam int LAT = 4;
`endif

  localparam int PH_IDLE  = 0;
  localparam int PH_ARMED = 1;
  localparam int PH_VALID = 2;
  localparam int PH_WAIT  = 3;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] sw    = '0;
  logic          ent   = 1'b1;
  logic          cmp_en = 1'b0;
  logic [7:0]    exp_cnt = 8'd0;

  int errors = 0;
  int checks = 0;

  entrada_chaves_if #(.DATA_W(DW)) bus ();

  entrada_chaves #(
    .DATA_W          (DW),
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (20)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .switch (sw),
    .ent    (ent),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: inputs become visible to the block two edges after they
  // are sampled; the key level changes after D consecutive disagreeing edges.
  logic          s_ent [2];
  logic          s_req [2];
  logic [DW-1:0] s_sw  [2];
  logic          m_db;
  int            m_run;
  int            m_phase;
  logic [DW-1:0] m_data;
  logic [7:0]    m_count;
  logic          k_vis;
  logic          r_vis;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_ent[0] = 1'b1; s_ent[1] = 1'b1;
      s_req[0] = 1'b0; s_req[1] = 1'b0;
      s_sw[0]  = '0;   s_sw[1]  = '0;
      m_db = 1'b1; m_run = 0; m_phase = PH_IDLE; m_data = '0; m_count = 8'd0;
    end else begin
      k_vis = s_ent[1];
      r_vis = s_req[1];
      case (m_phase)
        PH_IDLE:  if (r_vis && m_db) m_phase = PH_ARMED;
        PH_ARMED: begin
          if (!r_vis) m_phase = PH_IDLE;
          else if (!m_db) begin
            m_phase = PH_VALID;
            m_data  = s_sw[1];
            m_count = m_count + 8'd1;
          end
        end
        PH_VALID: if (!r_vis) m_phase = PH_WAIT;
        default:  if (m_db) m_phase = PH_IDLE;
      endcase
`ifdef ENTRADA_DEBOUNCE_EN
      if (k_vis != m_db) begin
        m_run = m_run + 1;
        if (m_run == D) begin
          m_db  = k_vis;
          m_run = 0;
        end
      end else m_run = 0;
`else
      m_db = k_vis;
`endif
      s_ent[1] = s_ent[0]; s_ent[0] = ent;
      s_req[1] = s_req[0]; s_req[0] = bus.rd_req;
      s_sw[1]  = s_sw[0];  s_sw[0]  = sw;
    end
  end

  always @(negedge clk) begin
    if (cmp_en && reset) begin
      chk("model_valid", {31'd0, bus.rd_valid}, {31'd0, (m_phase == PH_VALID)});
      chk("model_data", {16'd0, bus.rd_data}, {16'd0, m_data});
      chk("model_count", {24'd0, bus.rd_count}, {24'd0, m_count});
    end
  end

  task automatic capture(input logic [DW-1:0] v);
    int lat;
    int fall;
    @(negedge clk);
    bus.rd_req = 1'b1;
    sw = v;
    cyc(4);
    ent = 1'b0;
    lat = 0;
    for (int i = 1; i <= LAT + 20; i++) begin
      @(posedge clk); #1;
      if (bus.rd_valid) begin
        lat = i;
        break;
      end
    end
    exp_cnt = exp_cnt + 8'd1;
    chk("press_to_valid", lat, LAT);
    chk("cap_data", {16'd0, bus.rd_data}, {16'd0, v});
    chk("cap_count", {24'd0, bus.rd_count}, {24'd0, exp_cnt});
    @(negedge clk);
    bus.rd_req = 1'b0;
    fall = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (!bus.rd_valid) begin
        fall = i;
        break;
      end
    end
    chk("req_fall_to_valid_fall", fall, 3);
    ent = 1'b1;
    cyc(D + 6);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    int   n;
    bus.rd_req = 1'b0;
    #1 reset = 1'b0;
    cyc(3);
    chk("reset_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("reset_data", {16'd0, bus.rd_data}, 32'd0);
    chk("reset_count", {24'd0, bus.rd_count}, 32'd0);
    #2 reset = 1'b1;
    cmp_en = 1'b1;
    cyc(3);

    // Normal capture
    capture(16'hA5C3);
    chk("normal_count_is_1", {24'd0, bus.rd_count}, 32'd1);
    chk("normal_data_held", {16'd0, bus.rd_data}, 32'h0000A5C3);

    // Short glitch while armed
    @(negedge clk);
    bus.rd_req = 1'b1;
    sw = 16'h0F0F;
    cyc(4);
    ent = 1'b0;
    cyc(5);
    ent = 1'b1;
    cyc(D + 6);
`ifdef ENTRADA_DEBOUNCE_EN
    chk("glitch_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("glitch_count", {24'd0, bus.rd_count}, {24'd0, exp_cnt});
`else
    exp_cnt = exp_cnt + 8'd1;
    chk("glitch_valid", {31'd0, bus.rd_valid}, 32'd1);
    chk("glitch_count", {24'd0, bus.rd_count}, {24'd0, exp_cnt});
`endif
    bus.rd_req = 1'b0;
    cyc(D + 6);

    // Key already held when the request arrives
    ent = 1'b0;
    sw = 16'h3C3C;
    cyc(D + 6);
    bus.rd_req = 1'b1;
    cyc(D + 6);
    chk("held_no_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("held_count", {24'd0, bus.rd_count}, {24'd0, exp_cnt});
    ent = 1'b1;
    cyc(D + 6);
    ent = 1'b0;
    cyc(LAT + 3);
    exp_cnt = exp_cnt + 8'd1;
    chk("held_repress_valid", {31'd0, bus.rd_valid}, 32'd1);
    chk("held_repress_data", {16'd0, bus.rd_data}, 32'h00003C3C);
    bus.rd_req = 1'b0;
    cyc(4);
    ent = 1'b1;
    cyc(D + 6);

    // Abort before press, then press without a request
    bus.rd_req = 1'b1;
    cyc(4);
    bus.rd_req = 1'b0;
    cyc(4);
    ent = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < D + 8; i++) begin
      @(negedge clk);
      if (bus.rd_valid) seen = 1'b1;
    end
    chk("abort_no_valid", {31'd0, seen}, 32'd0);
    chk("abort_count", {24'd0, bus.rd_count}, {24'd0, exp_cnt});
    ent = 1'b1;
    cyc(D + 6);

    // Counter wrap
    n = 256 - int'(exp_cnt);
    for (int i = 0; i < n; i++) capture(DW'($urandom));
    chk("wrap_count_zero", {24'd0, bus.rd_count}, 32'd0);

    // Reset while VALID
    @(negedge clk);
    bus.rd_req = 1'b1;
    sw = 16'h1234;
    cyc(4);
    ent = 1'b0;
    cyc(LAT + 3);
    chk("pre_reset_valid", {31'd0, bus.rd_valid}, 32'd1);
    chk("pre_reset_data", {16'd0, bus.rd_data}, 32'h00001234);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("async_reset_data", {16'd0, bus.rd_data}, 32'd0);
    chk("async_reset_count", {24'd0, bus.rd_count}, 32'd0);
    ent = 1'b1;
    bus.rd_req = 1'b0;
    cyc(3);
    #2 reset = 1'b1;
    cyc(D + 6);
    chk("post_reset_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("post_reset_count", {24'd0, bus.rd_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
